// File: rtl/decode_pkg.sv
// Shared opcode/funct constants and the per-lane decoded record for the
// RV32I decode stage.
package decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam int IMM_W = 32;

    typedef struct packed {
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [IMM_W-1:0] imm;
        logic             load_flag;
        logic             store_flag;
        logic             illegal;
        logic             uses_rs1;
        logic             uses_rs2;
        logic             writes_rd;
    } dec_lane_t;

endpackage

// File: rtl/decode_lane.sv
// Combinational single-instruction RV32I decoder: register fields, immediate,
// class flags and legality for one lane.
module decode_lane
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output dec_lane_t   dec
);

    logic rd_class;

    always_comb begin
        dec        = '0;
        rd_class   = 1'b0;
        dec.opcode = instr[6:0];
        dec.funct3 = instr[14:12];
        dec.funct7 = instr[31:25];
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.rd     = instr[11:7];

        case (instr[6:0])
            OPC_LUI: begin
                rd_class = 1'b1;
                dec.imm  = {instr[31:12], 12'b0};
            end
            OPC_OP_IMM: begin
                rd_class     = 1'b1;
                dec.uses_rs1 = 1'b1;
                // funct3 x01 are the shifts: shamt immediate, funct7 constrained
                if (instr[13:12] == 2'b01) begin
                    dec.imm     = {27'b0, instr[24:20]};
                    dec.illegal = !((instr[31:25] == F7_BASE) ||
                                    (instr[31:25] == F7_ALT && instr[14]));
                end else begin
                    dec.imm = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OPC_LOAD: begin
                rd_class      = 1'b1;
                dec.uses_rs1  = 1'b1;
                dec.load_flag = 1'b1;
                dec.imm       = {{20{instr[31]}}, instr[31:20]};
                dec.illegal   = (instr[14:12] == 3'b011) || (instr[14:13] == 2'b11);
            end
            OPC_STORE: begin
                dec.uses_rs1   = 1'b1;
                dec.uses_rs2   = 1'b1;
                dec.store_flag = 1'b1;
                dec.imm        = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                dec.illegal    = instr[14] || (instr[13:12] == 2'b11);
            end
            OPC_OP: begin
                rd_class     = 1'b1;
                dec.uses_rs1 = 1'b1;
                dec.uses_rs2 = 1'b1;
                dec.illegal  = !((instr[31:25] == F7_BASE) ||
                                 (instr[31:25] == F7_ALT &&
                                  (instr[14:12] == 3'b000 || instr[14:12] == 3'b101)));
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase

        dec.writes_rd = rd_class && (instr[11:7] != 5'd0) && !dec.illegal;
    end

endmodule

// File: rtl/decode_stage.sv
// N-lane RV32I decode stage: per-lane combinational decode captured into a
// main/skid register pair so in_ready is a flop and throughput is one bundle/cycle.
module decode_stage
    import decode_pkg::*;
#(
    parameter int LANES = 2,
    parameter int XLEN  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES-1:0]      in_lane_mask,
    input  logic [LANES*32-1:0]   instr_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      lane_valid,
    output logic [LANES*7-1:0]    opcode,
    output logic [LANES*3-1:0]    funct3,
    output logic [LANES*7-1:0]    funct7,
    output logic [LANES*5-1:0]    rs1,
    output logic [LANES*5-1:0]    rs2,
    output logic [LANES*5-1:0]    rd,
    output logic [LANES*XLEN-1:0] imm,
    output logic [LANES-1:0]      load_flag,
    output logic [LANES-1:0]      store_flag,
    output logic [LANES-1:0]      illegal,
    output logic [LANES-1:0]      uses_rs1,
    output logic [LANES-1:0]      uses_rs2,
    output logic [LANES-1:0]      writes_rd
);

    dec_lane_t [LANES-1:0] dec_raw;
    dec_lane_t [LANES-1:0] dec_in;
    dec_lane_t [LANES-1:0] main_lanes;
    dec_lane_t [LANES-1:0] skid_lanes;
    logic      [LANES-1:0] main_mask;
    logic      [LANES-1:0] skid_mask;
    logic                  main_valid;
    logic                  skid_valid;
    logic                  accept;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        decode_lane u_decode_lane (
            .instr (instr_in[i*32 +: 32]),
            .dec   (dec_raw[i])
        );

        // masked-off lanes carry an all-zero record so downstream sees clean fields
        assign dec_in[i] = in_lane_mask[i] ? dec_raw[i] : '0;

        assign opcode[i*7 +: 7]       = main_lanes[i].opcode;
        assign funct3[i*3 +: 3]       = main_lanes[i].funct3;
        assign funct7[i*7 +: 7]       = main_lanes[i].funct7;
        assign rs1[i*5 +: 5]          = main_lanes[i].rs1;
        assign rs2[i*5 +: 5]          = main_lanes[i].rs2;
        assign rd[i*5 +: 5]           = main_lanes[i].rd;
        assign imm[i*XLEN +: XLEN]    = main_lanes[i].imm[XLEN-1:0];
        assign load_flag[i]           = main_lanes[i].load_flag;
        assign store_flag[i]          = main_lanes[i].store_flag;
        assign illegal[i]             = main_lanes[i].illegal;
        assign uses_rs1[i]            = main_lanes[i].uses_rs1;
        assign uses_rs2[i]            = main_lanes[i].uses_rs2;
        assign writes_rd[i]           = main_lanes[i].writes_rd;
    end

    assign in_ready   = !skid_valid;
    assign out_valid  = main_valid;
    assign lane_valid = main_mask;
    assign accept     = in_valid && in_ready && (|in_lane_mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_lanes <= '0;
            skid_lanes <= '0;
            main_mask  <= '0;
            skid_mask  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || out_ready) begin
            // skid_valid forces in_ready low, so a skid drain never races an accept
            if (skid_valid) begin
                main_lanes <= skid_lanes;
                main_mask  <= skid_mask;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_lanes <= dec_in;
                main_mask  <= in_lane_mask;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_lanes <= dec_in;
            skid_mask  <= in_lane_mask;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage (LANES=2): an occupancy-queue model of the
// buffer plus a rule-level RV32I decoder predict every output each cycle.
module tb_decode_stage;

    localparam int LANES = 2;
    localparam int XLEN  = 32;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        ld;
        logic        st;
        logic        ill;
        logic        u1;
        logic        u2;
        logic        wr;
    } exp_lane_t;

    logic                  clk = 1'b0;
    logic                  reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [LANES-1:0]      in_lane_mask, lane_valid;
    logic [LANES*32-1:0]   instr_in;
    logic [LANES*7-1:0]    opcode, funct7;
    logic [LANES*3-1:0]    funct3;
    logic [LANES*5-1:0]    rs1, rs2, rd;
    logic [LANES*XLEN-1:0] imm;
    logic [LANES-1:0]      load_flag, store_flag, illegal, uses_rs1, uses_rs2, writes_rd;

    int n_chk  = 0;
    int n_fail = 0;
    logic [65:0] q[$];   // {mask, instr1, instr0} of accepted bundles still buffered

    decode_stage #(.LANES(LANES), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_lane_mask(in_lane_mask),
        .instr_in(instr_in), .out_valid(out_valid), .out_ready(out_ready),
        .lane_valid(lane_valid), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .load_flag(load_flag), .store_flag(store_flag), .illegal(illegal),
        .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .writes_rd(writes_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_lane_t model(input logic [31:0] ins);
        exp_lane_t e;
        logic [6:0] op, f7;
        logic [2:0] f3;
        bit wcls;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        e = '0;
        e.opcode = op; e.funct3 = f3; e.funct7 = f7;
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        wcls = 0;
        if (op == 7'h37) begin
            e.imm = ins & 32'hFFFF_F000;
            wcls = 1;
        end else if (op == 7'h13) begin
            e.u1 = 1; wcls = 1;
            if (f3 == 1) begin
                e.imm = 32'(ins[24:20]);
                e.ill = (f7 != 0);
            end else if (f3 == 5) begin
                e.imm = 32'(ins[24:20]);
                e.ill = !(f7 == 0 || f7 == 7'h20);
            end else begin
                e.imm = 32'($signed(ins) >>> 20);
            end
        end else if (op == 7'h03) begin
            e.u1 = 1; e.ld = 1; wcls = 1;
            e.imm = 32'($signed(ins) >>> 20);
            e.ill = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        end else if (op == 7'h23) begin
            e.u1 = 1; e.u2 = 1; e.st = 1;
            e.imm = 32'(($signed(ins) >>> 25) * 32) + 32'(ins[11:7]);
            e.ill = (f3 > 2);
        end else if (op == 7'h33) begin
            e.u1 = 1; e.u2 = 1; wcls = 1;
            e.ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
        end else begin
            e.ill = 1;
        end
        e.wr = wcls && e.rd != 0 && !e.ill;
        return e;
    endfunction

    function automatic exp_lane_t dut_lane(input int i);
        return {opcode[i*7 +: 7], funct3[i*3 +: 3], funct7[i*7 +: 7],
                rs1[i*5 +: 5], rs2[i*5 +: 5], rd[i*5 +: 5], imm[i*32 +: 32],
                load_flag[i], store_flag[i], illegal[i], uses_rs1[i], uses_rs2[i], writes_rd[i]};
    endfunction

    task automatic check_all();
        logic [65:0] h;
        exp_lane_t e;
        chk("in_ready", 96'(in_ready), 96'(q.size() < 2));
        chk("out_valid", 96'(out_valid), 96'(q.size() > 0));
        if (q.size() > 0) begin
            h = q[0];
            chk("lane_valid", 96'(lane_valid), 96'(h[65:64]));
            for (int i = 0; i < LANES; i++) begin
                e = h[64 + i] ? model(h[i*32 +: 32]) : '0;
                chk($sformatf("lane%0d_fields", i), 96'(dut_lane(i)), 96'(e));
            end
        end
    endtask

    task automatic step(input logic rs, input logic fl, input logic v, input logic [1:0] m,
                        input logic [31:0] i0, input logic [31:0] i1, input logic rdy,
                        output bit acc);
        reset = rs; flush = fl; in_valid = v; in_lane_mask = m;
        instr_in = {i1, i0}; out_ready = rdy;
        acc = v && (q.size() < 2) && (m != 0);
        if (rs || fl) begin
            q.delete();
            acc = 0;
        end else begin
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (acc) q.push_back({m, i1, i0});
        end
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0] op, f7;
        r = $urandom();
        case ($urandom_range(0, 5))
            0: op = 7'h37;
            1: op = 7'h13;
            2: op = 7'h03;
            3: op = 7'h23;
            4: op = 7'h33;
            default: op = 7'($urandom());
        endcase
        case ($urandom_range(0, 2))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            default: f7 = 7'($urandom());
        endcase
        return {f7, r[24:7], op};
    endfunction

    bit acc;

    initial begin
        reset = 1; flush = 0; in_valid = 0; in_lane_mask = '0; instr_in = '0; out_ready = 0;
        @(negedge clk);
        step(1, 0, 0, 2'b00, 0, 0, 0, acc);
        step(0, 0, 0, 2'b00, 0, 0, 1, acc);

        // ADDI x1,x0,5 / LUI x2
        step(0, 0, 1, 2'b11, 32'h00500093, 32'h12345137, 1, acc);
        chk("addi_imm", 96'(imm[31:0]), 96'h5);
        chk("addi_rd", 96'(rd[4:0]), 96'd1);
        chk("addi_wr", 96'(writes_rd[0]), 96'd1);
        chk("lui_imm", 96'(imm[63:32]), 96'h12345000);
        chk("lui_urs1", 96'(uses_rs1[1]), 96'd0);

        // SW x5,-4(x2) / JAL
        step(0, 0, 1, 2'b11, 32'hFE512E23, 32'h0000006F, 1, acc);
        chk("sw_imm", 96'(imm[31:0]), 96'hFFFFFFFC);
        chk("sw_rs1", 96'(rs1[4:0]), 96'd2);
        chk("sw_rs2", 96'(rs2[4:0]), 96'd5);
        chk("sw_st", 96'(store_flag[0]), 96'd1);
        chk("sw_wr", 96'(writes_rd[0]), 96'd0);
        chk("sw_ill", 96'(illegal[0]), 96'd0);
        chk("jal_ill", 96'(illegal[1]), 96'd1);
        chk("jal_imm", 96'(imm[63:32]), 96'd0);

        // SRAI x3,x3,4
        step(0, 0, 1, 2'b01, 32'h4041D193, 32'h0, 1, acc);
        chk("srai_imm", 96'(imm[31:0]), 96'h4);
        chk("srai_ill", 96'(illegal[0]), 96'd0);
        step(0, 0, 0, 2'b00, 0, 0, 1, acc);

        // stall with A, B, C back to back; C must be held off then delivered in order
        step(0, 0, 1, 2'b11, rand_instr(), rand_instr(), 0, acc);
        step(0, 0, 1, 2'b11, rand_instr(), rand_instr(), 0, acc);
        step(0, 0, 1, 2'b11, 32'h00A00113, 32'h00B00193, 0, acc);
        chk("stall_c_held", 96'(acc), 96'd0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 2'b11, 32'h00A00113, 32'h00B00193, 1, acc);
            if (acc) break;
        end
        for (int k = 0; k < 3; k++) step(0, 0, 0, 2'b00, 0, 0, 1, acc);

        // lane masks
        step(0, 0, 1, 2'b10, 32'h00500093, 32'h12345137, 1, acc);
        chk("mask10_lv", 96'(lane_valid), 96'b10);
        step(0, 0, 0, 2'b00, 0, 0, 1, acc);
        step(0, 0, 1, 2'b00, 32'h00500093, 32'h12345137, 1, acc);
        chk("mask00_ov", 96'(out_valid), 96'd0);

        // full buffer then flush, then the same with reset
        for (int pass = 0; pass < 2; pass++) begin
            step(0, 0, 1, 2'b11, rand_instr(), rand_instr(), 0, acc);
            step(0, 0, 1, 2'b11, rand_instr(), rand_instr(), 0, acc);
            chk("full_inrdy", 96'(in_ready), 96'd0);
            step(pass == 1, pass == 0, 1, 2'b11, 32'h00100093, 32'h00200113, 0, acc);
            chk("drop_ov", 96'(out_valid), 96'd0);
            chk("drop_inrdy", 96'(in_ready), 96'd1);
            step(0, 0, 0, 2'b00, 0, 0, 1, acc);
            chk("drop_gone", 96'(out_valid), 96'd0);
        end

        // random traffic
        for (int k = 0; k < 2000; k++) begin
            step($urandom_range(0, 149) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 rand_instr(), rand_instr(), $urandom_range(0, 2) != 0, acc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
